muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 105 ++++++++++
 tb/tb_muldiv_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO register file and multiply/divide sequencing for the EXE stage
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hold_i,
  input  logic [63:0] mul_result_i,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic [31:0] div_opa_o,
  output logic [31:0] div_opb_o,
  output logic        div_annul_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        mul_signed_o,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [5:0]  div_busy_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  state_t state;
  logic   div_issue;

  // A divide leaves IDLE only when the EXE stage is not being flushed.
  always_comb begin
    div_issue    = (state == IDLE) && !flush && ((md_op == OP_DIV) || (md_op == OP_DIVU));
    mul_signed_o = (md_op == OP_MULT);
    // stall is gated by rst so reset forces it low even while a DIV op is presented
    stall_o      = rst && (div_issue || (state == DIV_RUN));
    div_annul_o  = (state == DIV_RUN) && flush;
  end

  // Main FSM: HI/LO commits, operand latching, busy counter and divider start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      hi_o           <= '0;
      lo_o           <= '0;
      div_opa_o      <= '0;
      div_opb_o      <= '0;
      div_signed_o   <= 1'b0;
      div_busy_cnt_o <= '0;
      div_start_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush) begin
            case (md_op)
              OP_MULT, OP_MULTU: {hi_o, lo_o} <= mul_result_i;
              OP_MTHI:           hi_o <= a;
              OP_MTLO:           lo_o <= a;
              OP_DIV, OP_DIVU: begin
                div_opa_o      <= a;
                div_opb_o      <= b;
                div_signed_o   <= (md_op == OP_DIV);
                div_busy_cnt_o <= '0;
                div_start_o    <= 1'b1;
                state          <= DIV_RUN;
              end
              default: ;
            endcase
          end
        end
        DIV_RUN: begin
          if (div_busy_cnt_o != 6'd63) div_busy_cnt_o <= div_busy_cnt_o + 6'd1;
          // flush wins over a same-cycle ready: the result is discarded
          if (flush) begin
            div_start_o <= 1'b0;
            state       <= IDLE;
          end else if (div_ready_i) begin
            {hi_o, lo_o} <= div_result_i;
            div_start_o  <= 1'b0;
            state        <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          // parked here while held so the same DIV is not reissued
          if (flush || !hold_i) state <= IDLE;
        end
        default: begin
          div_start_o <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        flush, hold_i;
  logic [63:0] mul_result_i;
  logic        div_start_o, div_signed_o;
  logic [31:0] div_opa_o, div_opb_o;
  logic        div_annul_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        mul_signed_o, stall_o;
  logic [31:0] hi_o, lo_o;
  logic [5:0]  div_busy_cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;
  logic [31:0] mhi, mlo;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .md_op(md_op), .a(a), .b(b), .flush(flush),
    .hold_i(hold_i), .mul_result_i(mul_result_i), .div_start_o(div_start_o),
    .div_signed_o(div_signed_o), .div_opa_o(div_opa_o), .div_opb_o(div_opb_o),
    .div_annul_o(div_annul_o), .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .mul_signed_o(mul_signed_o), .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o),
    .div_busy_cnt_o(div_busy_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; md_op = 3'b011; a = 32'h5; b = 32'h6; flush = 1'b0; hold_i = 1'b0;
    mul_result_i = '0; div_result_i = '0; div_ready_i = 1'b0;
    #2;
    n_cmp++;
    if ({stall_o, div_start_o, div_annul_o, div_signed_o} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctl: got %b want 0000", {stall_o, div_start_o, div_annul_o, div_signed_o});
    end
    tick(); tick();
    n_cmp++;
    if ({hi_o, lo_o, div_opa_o, div_opb_o, div_busy_cnt_o} !== '0) begin
      n_err++; $display("FAIL reset_regs: hi=%h lo=%h opa=%h opb=%h cnt=%0d want all 0",
                        hi_o, lo_o, div_opa_o, div_opb_o, div_busy_cnt_o);
    end
    md_op = 3'b000;
    #2 rst = 1'b1;
    mhi = 0; mlo = 0;
    tick();
  endtask

  task automatic test_mult();
    md_op = 3'b001; a = 32'hFFFFFFFE; b = 32'd3; mul_result_i = 64'hFFFFFFFF_FFFFFFFA;
    mhi = 32'hFFFFFFFF; mlo = 32'hFFFFFFFA; exp_q.push_back({mhi, mlo});
    #1;
    n_cmp++;
    if ({mul_signed_o, stall_o} !== 2'b10) begin
      n_err++; $display("FAIL mult_ctl: signed/stall=%b want 10", {mul_signed_o, stall_o});
    end
    tick();
    md_op = 3'b000;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if ({hi_o, lo_o} !== exp_v || stall_o !== 1'b0) begin
      n_err++; $display("FAIL mult_hilo: got %h stall=%b want %h stall=0", {hi_o, lo_o}, stall_o, exp_v);
    end
    md_op = 3'b010; a = 32'hFFFFFFFF; b = 32'd2; mul_result_i = 64'h00000001_FFFFFFFE;
    mhi = 32'h1; mlo = 32'hFFFFFFFE; exp_q.push_back({mhi, mlo});
    #1;
    n_cmp++;
    if (mul_signed_o !== 1'b0) begin
      n_err++; $display("FAIL multu_signed: got %b want 0", mul_signed_o);
    end
    tick();
    md_op = 3'b111; mul_result_i = 64'hDEAD_BEEF_0000_1111;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if ({hi_o, lo_o} !== exp_v) begin
      n_err++; $display("FAIL multu_hilo: got %h want %h", {hi_o, lo_o}, exp_v);
    end
    exp_q.push_back({mhi, mlo});
    tick();
    md_op = 3'b000;
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if ({hi_o, lo_o} !== exp_v) begin
      n_err++; $display("FAIL nop_codes: got %h want %h", {hi_o, lo_o}, exp_v);
    end
  endtask

  task automatic test_mt();
    md_op = 3'b101; a = 32'h12345678;
    mhi = 32'h12345678; exp_q.push_back({mhi, mlo});
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if ({hi_o, lo_o} !== exp_v) begin
      n_err++; $display("FAIL mthi: got %h want %h", {hi_o, lo_o}, exp_v);
    end
    md_op = 3'b110; a = 32'h9ABCDEF0;
    mlo = 32'h9ABCDEF0; exp_q.push_back({mhi, mlo});
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if ({hi_o, lo_o} !== exp_v) begin
      n_err++; $display("FAIL mtlo: got %h want %h", {hi_o, lo_o}, exp_v);
    end
    md_op = 3'b101; a = 32'hCAFEBABE; flush = 1'b1;
    exp_q.push_back({mhi, mlo});
    tick();
    flush = 1'b0; md_op = 3'b000;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if ({hi_o, lo_o} !== exp_v) begin
      n_err++; $display("FAIL mthi_flush: got %h want %h", {hi_o, lo_o}, exp_v);
    end
  endtask

  task automatic test_divu();
    md_op = 3'b100; a = 32'd100; b = 32'd7;
    #1;
    n_cmp++;
    if ({stall_o, div_start_o} !== 2'b10) begin
      n_err++; $display("FAIL divu_issue: stall/start=%b want 10", {stall_o, div_start_o});
    end
    tick();
    md_op = 3'b000; a = 32'hAAAA5555; b = 32'h0;
    for (int k = 1; k <= 33; k++) begin
      if (k == 33) begin
        div_ready_i = 1'b1; div_result_i = {32'd2, 32'd14};
        mhi = 32'd2; mlo = 32'd14; exp_q.push_back({mhi, mlo});
      end
      #1;
      n_cmp++;
      if ({stall_o, div_start_o, div_signed_o} !== 3'b110 || div_opa_o !== 32'd100 ||
          div_opb_o !== 32'd7 || div_busy_cnt_o !== 6'(k - 1)) begin
        n_err++; $display("FAIL divu_run[%0d]: stall/start/signed=%b opa=%0d opb=%0d cnt=%0d want 110 100 7 %0d",
                          k, {stall_o, div_start_o, div_signed_o}, div_opa_o, div_opb_o, div_busy_cnt_o, k - 1);
      end
      tick();
    end
    div_ready_i = 1'b0;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if ({stall_o, div_start_o} !== 2'b00 || {hi_o, lo_o} !== exp_v || div_busy_cnt_o !== 6'd33) begin
      n_err++; $display("FAIL divu_done: stall/start=%b hilo=%h cnt=%0d want 00 %h 33",
                        {stall_o, div_start_o}, {hi_o, lo_o}, div_busy_cnt_o, exp_v);
    end
    tick();
    md_op = 3'b110; a = 32'h0000_00AA;
    mlo = 32'hAA; exp_q.push_back({mhi, mlo});
    tick();
    md_op = 3'b000;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if ({hi_o, lo_o} !== exp_v || div_start_o !== 1'b0) begin
      n_err++; $display("FAIL divu_idle: hilo=%h start=%b want %h 0", {hi_o, lo_o}, div_start_o, exp_v);
    end
  endtask

  task automatic test_div_flush();
    md_op = 3'b011; a = 32'hFFFFFFEC; b = 32'd3;
    tick();
    md_op = 3'b000;
    n_cmp++;
    if (div_signed_o !== 1'b1 || div_opa_o !== 32'hFFFFFFEC) begin
      n_err++; $display("FAIL div_latch: signed=%b opa=%h want 1 ffffffec", div_signed_o, div_opa_o);
    end
    for (int k = 1; k < 5; k++) tick();
    flush = 1'b1; div_ready_i = 1'b1; div_result_i = 64'h1111_2222_3333_4444;
    exp_q.push_back({mhi, mlo});
    #1;
    n_cmp++;
    if (div_annul_o !== 1'b1) begin
      n_err++; $display("FAIL flush_annul: got %b want 1", div_annul_o);
    end
    tick();
    flush = 1'b0; div_ready_i = 1'b0;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if ({div_annul_o, div_start_o, stall_o} !== 3'b000 || {hi_o, lo_o} !== exp_v) begin
      n_err++; $display("FAIL flush_after: annul/start/stall=%b hilo=%h want 000 %h",
                        {div_annul_o, div_start_o, stall_o}, {hi_o, lo_o}, exp_v);
    end
  endtask

  task automatic test_div_hold();
    hold_i = 1'b1;
    md_op = 3'b100; a = 32'd50; b = 32'd8;
    tick();
    md_op = 3'b001; mul_result_i = 64'hBAD0_BAD0_BAD0_BAD0;
    tick(); tick();
    div_ready_i = 1'b1; div_result_i = {32'd2, 32'd6};
    mhi = 32'd2; mlo = 32'd6;
    tick();
    div_ready_i = 1'b0; md_op = 3'b101; a = 32'hEEEE_EEEE;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) hold_i = 1'b0;
      exp_q.push_back({mhi, mlo});
      #1;
      n_cmp++;
      if ({stall_o, div_start_o} !== 2'b00) begin
        n_err++; $display("FAIL hold_done[%0d]: stall/start=%b want 00", k, {stall_o, div_start_o});
      end
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if ({hi_o, lo_o} !== exp_v) begin
        n_err++; $display("FAIL hold_hilo[%0d]: got %h want %h", k, {hi_o, lo_o}, exp_v);
      end
    end
    md_op = 3'b000;
    n_cmp++;
    if ({stall_o, div_start_o} !== 2'b00) begin
      n_err++; $display("FAIL hold_idle: stall/start=%b want 00", {stall_o, div_start_o});
    end
  endtask

  task automatic test_busy_sat();
    md_op = 3'b100; a = 32'd1; b = 32'd0;
    tick();
    md_op = 3'b000;
    for (int k = 0; k < 70; k++) tick();
    n_cmp++;
    if (div_busy_cnt_o !== 6'd63 || stall_o !== 1'b1) begin
      n_err++; $display("FAIL busy_sat: cnt=%0d stall=%b want 63 1", div_busy_cnt_o, stall_o);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset_mid_div();
    md_op = 3'b011; a = 32'd77; b = 32'd5;
    tick();
    md_op = 3'b000;
    tick(); tick();
    rst = 1'b0;
    #1;
    mhi = 0; mlo = 0; exp_q.push_back({mhi, mlo});
    exp_v = exp_q.pop_front();
    n_cmp++;
    if ({stall_o, div_start_o, div_annul_o, div_signed_o} !== 4'b0 || {hi_o, lo_o} !== exp_v ||
        div_opa_o !== 32'd0 || div_opb_o !== 32'd0 || div_busy_cnt_o !== 6'd0) begin
      n_err++; $display("FAIL reset_mid: ctl=%b hilo=%h opa=%h opb=%h cnt=%0d want zeros",
                        {stall_o, div_start_o, div_annul_o, div_signed_o}, {hi_o, lo_o}, div_opa_o, div_opb_o, div_busy_cnt_o);
    end
    tick();
    rst = 1'b1;
    tick();
    md_op = 3'b100; a = 32'd9; b = 32'd2;
    tick();
    md_op = 3'b000;
    n_cmp++;
    if (div_start_o !== 1'b1 || div_opa_o !== 32'd9 || div_opb_o !== 32'd2 || div_busy_cnt_o !== 6'd0) begin
      n_err++; $display("FAIL restart: start=%b opa=%0d opb=%0d cnt=%0d want 1 9 2 0",
                        div_start_o, div_opa_o, div_opb_o, div_busy_cnt_o);
    end
    tick();
    div_ready_i = 1'b1; div_result_i = {32'd1, 32'd4};
    mhi = 32'd1; mlo = 32'd4; exp_q.push_back({mhi, mlo});
    tick();
    div_ready_i = 1'b0;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if ({hi_o, lo_o} !== exp_v || div_busy_cnt_o !== 6'd2) begin
      n_err++; $display("FAIL restart_done: hilo=%h cnt=%0d want %h 2", {hi_o, lo_o}, div_busy_cnt_o, exp_v);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_mult();
    test_mt();
    test_divu();
    test_div_flush();
    test_div_hold();
    test_busy_sat();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
